// File: rtl/nt_pkg.sv
// Shared definitions for the neurotransmitter update scheduler.
package nt_pkg;

    localparam int NT_COUNT = 5;

    // NT indices: walk order and bus packing order
    localparam int NT_CORT = 0;
    localparam int NT_DOP  = 1;
    localparam int NT_GABA = 2;
    localparam int NT_NE   = 3;
    localparam int NT_SER  = 4;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        COMMIT
    } nt_sched_state_t;

    // Quantised 2-bit level codes (top two bits of a fine counter)
    localparam logic [1:0] LVL_LOW      = 2'b00;
    localparam logic [1:0] LVL_MED_LOW  = 2'b01;
    localparam logic [1:0] LVL_MED_HIGH = 2'b10;
    localparam logic [1:0] LVL_HIGH     = 2'b11;

    // All counters sit at the midpoint after reset
    localparam logic [2*NT_COUNT-1:0] LEVEL_RESET = {NT_COUNT{LVL_MED_HIGH}};

endpackage

// File: rtl/nt_update_scheduler_step.sv
// Combinational saturating step for one fine level counter.
module nt_step_unit #(
    parameter int CNT_W     = 6,
    parameter int FAST_STEP = 4
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    input  logic             decay_en,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [CNT_W-1:0] MID = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W:0] step;
    logic [CNT_W:0] sum;
    logic [CNT_W:0] diff;

    // Dec dominates inc; decay only when neither is requested; clamp instead of wrap
    always_comb begin
        step     = fast ? (CNT_W+1)'(FAST_STEP) : (CNT_W+1)'(1);
        sum      = {1'b0, cnt} + step;
        diff     = {1'b0, cnt} - step;
        cnt_next = cnt;
        if (dec) begin
            cnt_next = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
        end else if (inc) begin
            cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (decay_en) begin
            if (cnt > MID) begin
                cnt_next = cnt - CNT_W'(1);
            end else if (cnt < MID) begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nt_update_scheduler.sv
// Walks one shared step unit over the five NT counters per tick and
// commits the quantised levels to the output bus in a single cycle.
module nt_update_scheduler
    import nt_pkg::*;
#(
    parameter int CNT_W        = 6,
    parameter int FAST_STEP    = 4,
    parameter int DECAY_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  tick,
    input  logic [NT_COUNT-1:0]   req_inc,
    input  logic [NT_COUNT-1:0]   req_dec,
    input  logic [NT_COUNT-1:0]   req_fast,
    output logic [2*NT_COUNT-1:0] neurotransmitter_level,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int RC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [CNT_W-1:0] MID = {1'b1, {(CNT_W-1){1'b0}}};

    nt_sched_state_t     state;
    logic [2:0]          idx;
    logic [NT_COUNT-1:0] snap_inc;
    logic [NT_COUNT-1:0] snap_dec;
    logic [NT_COUNT-1:0] snap_fast;
    logic [CNT_W-1:0]    cnt [NT_COUNT];
    logic [RC_W-1:0]     round_cnt;
    logic                pending;
    logic                decay_en;
    logic [CNT_W-1:0]    step_next;

    assign decay_en = (round_cnt == RC_W'(DECAY_PERIOD - 1));

    nt_step_unit #(
        .CNT_W     (CNT_W),
        .FAST_STEP (FAST_STEP)
    ) u_step (
        .cnt      (cnt[idx]),
        .inc      (snap_inc[idx]),
        .dec      (snap_dec[idx]),
        .fast     (snap_fast[idx]),
        .decay_en (decay_en),
        .cnt_next (step_next)
    );

    // Round sequencer: snapshot, per-NT update, single-cycle commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            idx                   <= '0;
            snap_inc              <= '0;
            snap_dec              <= '0;
            snap_fast             <= '0;
            round_cnt             <= '0;
            pending               <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            overrun               <= 1'b0;
            neurotransmitter_level <= LEVEL_RESET;
            for (int unsigned i = 0; i < NT_COUNT; i++) begin
                cnt[i] <= MID;
            end
        end else begin
            done <= 1'b0;
            if (ena) begin
                // Ticks during a round queue once; a second queued tick is lost
                if (state != IDLE && tick) begin
                    if (pending) begin
                        overrun <= 1'b1;
                    end else begin
                        pending <= 1'b1;
                    end
                end
                case (state)
                    IDLE: begin
                        if (tick || pending) begin
                            snap_inc  <= req_inc;
                            snap_dec  <= req_dec;
                            snap_fast <= req_fast;
                            idx       <= '0;
                            busy      <= 1'b1;
                            state     <= UPDATE;
                            // a fresh tick arriving as a queued one starts stays queued
                            pending   <= pending && tick;
                        end
                    end
                    UPDATE: begin
                        cnt[idx] <= step_next;
                        if (idx == 3'(NT_SER)) begin
                            state <= COMMIT;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    COMMIT: begin
                        for (int unsigned i = 0; i < NT_COUNT; i++) begin
                            neurotransmitter_level[2*i +: 2] <= cnt[i][CNT_W-1 -: 2];
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (decay_en) begin
                            round_cnt <= '0;
                        end else begin
                            round_cnt <= round_cnt + RC_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nt_update_scheduler.sv
// Self-checking bench for nt_update_scheduler against a round-level model.
module tb_nt_update_scheduler;

    localparam int CNT_W        = 6;
    localparam int FAST_STEP    = 4;
    localparam int DECAY_PERIOD = 4;
    localparam int MID          = 1 << (CNT_W - 1);
    localparam int MAXV         = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] req_inc = '0;
    logic [4:0] req_dec = '0;
    logic [4:0] req_fast = '0;
    logic [9:0] neurotransmitter_level;
    logic       busy;
    logic       done;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt [5];
    int m_round;

    always #5 clk = ~clk;

    nt_update_scheduler #(
        .CNT_W        (CNT_W),
        .FAST_STEP    (FAST_STEP),
        .DECAY_PERIOD (DECAY_PERIOD)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ena                    (ena),
        .tick                   (tick),
        .req_inc                (req_inc),
        .req_dec                (req_dec),
        .req_fast               (req_fast),
        .neurotransmitter_level (neurotransmitter_level),
        .busy                   (busy),
        .done                   (done),
        .overrun                (overrun)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int n = 0; n < 5; n++) m_cnt[n] = MID;
        m_round = 0;
    endfunction

    function automatic void model_round(input logic [4:0] i, input logic [4:0] d, input logic [4:0] f);
        bit decay;
        int s;
        decay = ((m_round % DECAY_PERIOD) == DECAY_PERIOD - 1);
        for (int n = 0; n < 5; n++) begin
            s = f[n] ? FAST_STEP : 1;
            if (d[n]) begin
                m_cnt[n] = (m_cnt[n] - s < 0) ? 0 : m_cnt[n] - s;
            end else if (i[n]) begin
                m_cnt[n] = (m_cnt[n] + s > MAXV) ? MAXV : m_cnt[n] + s;
            end else if (decay) begin
                if (m_cnt[n] > MID) m_cnt[n] = m_cnt[n] - 1;
                else if (m_cnt[n] < MID) m_cnt[n] = m_cnt[n] + 1;
            end
        end
        m_round++;
    endfunction

    function automatic logic [9:0] model_bus();
        logic [9:0] b;
        for (int n = 0; n < 5; n++) b[2*n +: 2] = 2'(m_cnt[n] / (1 << (CNT_W - 2)));
        return b;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_inc  = 5'($urandom);
        req_dec  = 5'($urandom);
        req_fast = 5'($urandom);
    endtask

    task automatic apply_reset();
        ena   = 1'b1;
        tick  = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        model_reset();
    endtask

    // One full round; optionally stalls with random ena-low cycles
    task automatic run_round(input logic [4:0] i, input logic [4:0] d, input logic [4:0] f,
                             input bit stall, input string tag);
        int en_edges;
        int iters;
        req_inc  = i;
        req_dec  = d;
        req_fast = f;
        ena      = 1'b1;
        tick     = 1'b1;
        step();
        tick     = 1'b0;
        en_edges = 1;
        iters    = 0;
        model_round(i, d, f);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_start: got %b want 1", tag, busy);
        end
        while (done !== 1'b1 && iters < 80) begin
            scramble();
            ena = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            if (ena) en_edges++;
            iters++;
        end
        ena = 1'b1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: got %b want 1", tag, done);
        end
        n_tests++;
        if (en_edges != 7) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 7", tag, en_edges);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_end: got %b want 0", tag, busy);
        end
        n_tests++;
        if (neurotransmitter_level !== model_bus()) begin
            n_fail++;
            $display("FAIL %s bus: got %b want %b", tag, neurotransmitter_level, model_bus());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        model_reset();
        n_tests++;
        if (neurotransmitter_level !== 10'b1010101010) begin
            n_fail++;
            $display("FAIL reset_bus: got %b want 1010101010", neurotransmitter_level);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_single_round();
        apply_reset();
        run_round(5'b00010, 5'b00000, 5'b00010, 1'b0, "single");
        n_tests++;
        if (neurotransmitter_level !== 10'b1010101010) begin
            n_fail++;
            $display("FAIL single_bus_const: got %b want 1010101010", neurotransmitter_level);
        end
    endtask

    task automatic test_dominance_saturation();
        apply_reset();
        for (int r = 0; r < 9; r++) run_round(5'b00001, 5'b00001, 5'b00001, 1'b0, "dominance");
        n_tests++;
        if (neurotransmitter_level[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL cort_floor: got %b want 00", neurotransmitter_level[1:0]);
        end
        for (int r = 0; r < 16; r++) run_round(5'b00001, 5'b00000, 5'b00001, 1'b0, "saturate");
        n_tests++;
        if (neurotransmitter_level[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL cort_ceiling: got %b want 11", neurotransmitter_level[1:0]);
        end
    endtask

    task automatic test_decay();
        int probes;
        apply_reset();
        for (int r = 0; r < 8; r++) run_round(5'b01000, 5'b00000, 5'b00000, 1'b0, "ne_preload");
        for (int r = 0; r < 8; r++) run_round(5'b00000, 5'b00000, 5'b00000, 1'b0, "decay");
        // NE should now sit at 38: exactly 10 single increments reach 48 (field 11)
        probes = 0;
        while (neurotransmitter_level[7:6] !== 2'b11 && probes < 20) begin
            run_round(5'b01000, 5'b00000, 5'b00000, 1'b0, "ne_probe");
            probes++;
        end
        n_tests++;
        if (probes != 10) begin
            n_fail++;
            $display("FAIL decay_ne_value: got %0d probe rounds want 10", probes);
        end
    endtask

    task automatic test_burst();
        logic [4:0] r1i, r1d, r1f, r2i, r2d, r2f;
        logic [9:0] exp1, exp2, bus1, bus2;
        int first, second, pulses;
        apply_reset();
        r1i = 5'($urandom); r1d = 5'($urandom); r1f = 5'($urandom);
        r2i = 5'($urandom); r2d = 5'($urandom); r2f = 5'($urandom);
        model_round(r1i, r1d, r1f);
        exp1 = model_bus();
        model_round(r2i, r2d, r2f);
        exp2 = model_bus();
        first = -1; second = -1; pulses = 0;
        bus1 = '0; bus2 = '0;
        for (int c = 0; c <= 25; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin first = c; bus1 = neurotransmitter_level; end
                else if (second < 0) begin second = c; bus2 = neurotransmitter_level; end
            end
            if (c == 3) begin
                n_tests++;
                if (overrun !== 1'b0) begin n_fail++; $display("FAIL burst_overrun_early: got %b want 0", overrun); end
            end
            if (c == 4) begin
                n_tests++;
                if (overrun !== 1'b1) begin n_fail++; $display("FAIL burst_overrun_set: got %b want 1", overrun); end
            end
            if (c == 8) begin
                n_tests++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_second_busy: got %b want 1", busy); end
            end
            tick = (c == 0 || c == 2 || c == 3);
            if (c == 0) begin
                req_inc = r1i; req_dec = r1d; req_fast = r1f;
            end else if (c == 7) begin
                req_inc = r2i; req_dec = r2d; req_fast = r2f;
            end else begin
                scramble();
            end
            step();
        end
        tick = 1'b0;
        n_tests++;
        if (first != 7) begin n_fail++; $display("FAIL burst_first_done: got cycle %0d want 7", first); end
        n_tests++;
        if (second != 14) begin n_fail++; $display("FAIL burst_second_done: got cycle %0d want 14", second); end
        n_tests++;
        if (pulses != 2) begin n_fail++; $display("FAIL burst_pulses: got %0d want 2", pulses); end
        n_tests++;
        if (bus1 !== exp1) begin n_fail++; $display("FAIL burst_bus1: got %b want %b", bus1, exp1); end
        n_tests++;
        if (bus2 !== exp2) begin n_fail++; $display("FAIL burst_bus2: got %b want %b", bus2, exp2); end
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL burst_overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_async_reset();
        bit saw_activity;
        apply_reset();
        for (int r = 0; r < 4; r++) run_round(5'b11111, 5'b00000, 5'b11111, 1'b0, "preload_all");
        scramble();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (neurotransmitter_level !== 10'b1010101010) begin
            n_fail++;
            $display("FAIL async_bus: got %b want 1010101010", neurotransmitter_level);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
        step();
        rst_n = 1'b1;
        model_reset();
        saw_activity = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_activity = 1'b1;
            step();
        end
        n_tests++;
        if (saw_activity) begin n_fail++; $display("FAIL async_no_done: got activity want idle"); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL async_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_enable();
        bit started;
        apply_reset();
        ena  = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        ena  = 1'b1;
        started = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (busy !== 1'b0) started = 1'b1;
            step();
        end
        n_tests++;
        if (started) begin n_fail++; $display("FAIL ena_tick_ignored: got busy want idle"); end
        for (int r = 0; r < 6; r++)
            run_round(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, "stall");
    endtask

    task automatic test_random();
        apply_reset();
        for (int r = 0; r < 40; r++) begin
            run_round(5'($urandom), 5'($urandom), 5'($urandom), bit'($urandom_range(0, 1)), "random");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_round();
        test_dominance_saturation();
        test_decay();
        test_burst();
        test_async_reset();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nt_update_scheduler.md
# nt_update_scheduler

Sequences the per-cycle update of the five internal neurotransmitter levels (cortisol, dopamine, GABA, norepinephrine, serotonin) from the inc/dec/fast requests of the five `nt_*_regulator` blocks. On each timebase tick it snapshots all requests, then walks one shared saturating step unit over five fine-grained level counters in fixed order. It commits the quantised 2-bit levels to the packed `neurotransmitter_level` bus in a single cycle, so every regulator sees a coherent state. It sits between the regulators and the emotional-state logic, and is the only writer of the levels.

## Interface
Parameters:
- `CNT_W`, 6: width of each fine level counter (≥3).
- `FAST_STEP`, 4: step size when `fast` is set (normal step is 1; must be < 2^(CNT_W-1)).
- `DECAY_PERIOD`, 4: number of completed rounds between decay steps (≥1).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: global enable. When low, the FSM and all registers hold, and ticks are ignored.
- `tick`  in  1: one-cycle update strobe from the timebase.
- `req_inc`  in  5: inc request per NT. The bit index is the NT index.
- `req_dec`  in  5: dec request per NT.
- `req_fast`  in  5: fast request per NT.
- `neurotransmitter_level`  out  10: packed levels `{SER,NE,GABA,DOP,CORT}`, 2 bits each. Each field is the top 2 bits of its counter.
- `busy`  out  1: high while a round is in progress.
- `done`  out  1: one-cycle pulse. It is high in the first cycle in which the new levels are visible.
- `overrun`  out  1: sticky flag, set when a tick is dropped. Cleared only by reset.

## Operation
- NT index order: 0 CORT, 1 DOP, 2 GABA, 3 NE, 4 SER. This order is both the walk order and the bus packing order.
- FSM states: IDLE, UPDATE, COMMIT.
  - IDLE → UPDATE on `tick` (or on a pending tick). The three request vectors are snapshotted and `idx` is set to 0.
  - UPDATE: one counter is processed per cycle, at `idx`. `idx` increments, and after `idx==4` the FSM goes to COMMIT.
  - COMMIT: the output register is loaded from all five counters' top bits, `done` is scheduled, the round counter is advanced, and the FSM returns to IDLE.
- Per-NT step rule, applied to the snapshotted bits:
  - If dec is set, the counter is decremented. Dec wins when inc and dec are both set (reducing-dominant).
  - Else if inc is set, the counter is incremented.
  - Else, on a decay round only, the counter moves 1 toward the midpoint 2^(CNT_W-1). A counter already at the midpoint is unchanged.
  - The step is `FAST_STEP` if fast is set, else 1. Fast is ignored for decay.
- Saturation: results clamp to 0 and 2^CNT_W−1. There is no wrap-around. Arithmetic is done at CNT_W+1 bits before the clamp.
- Decay round: the round counter reads `DECAY_PERIOD−1` during the round. The counter is modulo `DECAY_PERIOD` and advances in COMMIT.
- Tick while `busy`: the tick is held in a 1-deep `pending` flag. A tick that arrives while `pending` is already set is dropped, and `overrun` is set. A pending tick starts the next round directly from IDLE, with the snapshot taken in that IDLE cycle.
- Requests that change mid-round have no effect. Only the snapshot is used.
- Reset, including during a round:
  - All counters go to 2^(CNT_W-1).
  - `neurotransmitter_level` = 10'b1010101010.
  - The FSM goes to IDLE, and `busy`, `done`, `overrun`, `pending`, `idx` and the round counter all clear to 0.

## Timing
- Tick is high in cycle 0 in IDLE.
- Cycles 1–5: UPDATE for idx 0–4, with `busy`=1.
- Cycle 6: COMMIT, with `busy`=1.
- Cycle 7: the new levels are on the bus, `done`=1 and `busy`=0.
- Latency from tick to levels is 7 cycles. The minimum round spacing is 7 cycles (IDLE, then 6 busy cycles).
- All outputs are registered. `neurotransmitter_level` changes only on the cycle following COMMIT.
- When `ena` is low, the whole round stalls cycle-for-cycle and `done` is not asserted. A `done` pulse that was already asserted deasserts normally.

## Structure
- Package `nt_pkg` holds:
  - `NT_COUNT`=5.
  - The index localparams `NT_CORT`, `NT_DOP`, `NT_GABA`, `NT_NE`, `NT_SER`.
  - The state enum `nt_sched_state_t` (IDLE/UPDATE/COMMIT).
  - The 2-bit level codes.
- Sub-module `nt_step_unit`: a combinational saturating step. Its inputs are the counter, inc, dec, fast and decay_en; its output is the next counter value. It is instantiated once and shared across all NTs.

## Test plan
- Reset: release `rst_n` → bus = 10'b1010101010, `busy`=0, `done`=0, `overrun`=0.
- Single round with CNT_W=6: `req_inc`=5'b00010, `req_fast`=5'b00010, tick → `done` in cycle 7. DOP counter goes 32→36, so the DOP field = 2'b10 and all other fields are unchanged.
- Dominance and saturation: `req_inc`=`req_dec`=5'b00001 with fast, repeated for 9 rounds → CORT counter 32→0, clamped, and the field is 2'b00. Then drive `req_inc` only, fast, for 16 rounds → counter 63, not wrapped, and the field is 2'b11.
- Decay with DECAY_PERIOD=4: NE preloaded to 40 via inc rounds, then requests held at 0 for 8 rounds → NE is 39 after round 4 and 38 after round 8. SER stays at 32.
- Ticks in a burst: a tick at cycle 0, a tick at cycle 2, and a tick at cycle 3 → two rounds run back to back, with the second starting in cycle 7. The third tick is dropped and `overrun`=1.
- Async reset in the middle of a round (cycle 3) → the bus immediately returns to 10'b1010101010, the FSM is in IDLE, and no `done` pulse follows.
